// File: rtl/pe_array_feeder.sv
// Transmit-side sequencer for the 32x32 motion-estimation PE array.
// Pulls current-block rows and reference rows from two valid/ready
// streams and drives the array's shift/load strobes, the abs_Control
// sweep and the compare tags consumed by the SAD tree. Every output is
// a register, so a handshake in one cycle shows up at the array pins in
// the next.
module pe_array_feeder #(
   parameter int PIXEL          = 8,
   parameter int X              = 32,
   parameter int CURR_ROWS      = 32,
   parameter int REF_INIT_BEATS = 4,
   parameter int SEARCH_ROWS    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   cb_pair,
   output logic                   busy,
   output logic                   done,
   input  logic [2*X*PIXEL-1:0]   curr_data,
   input  logic                   curr_valid,
   output logic                   curr_ready,
   input  logic [8*X*PIXEL-1:0]   ref_data,
   input  logic                   ref_valid,
   output logic                   ref_ready,
   output logic [2*X*PIXEL-1:0]   current_64pixels,
   output logic                   in_curr_enable,
   output logic                   CB_select,
   output logic [1:0]             abs_Control,
   output logic [8*X*PIXEL-1:0]   ref_8R_32,
   output logic                   change_ref,
   output logic                   ref_input_Control,
   output logic                   abs_valid,
   output logic [5:0]             pos_idx
);

   // Counter widths sized so the terminal value always fits.
   localparam int CCW = $clog2(CURR_ROWS + 1);
   localparam int RCW = $clog2(REF_INIT_BEATS + 1);

   localparam logic [CCW-1:0] CURR_LAST   = CCW'(CURR_ROWS - 1);
   localparam logic [RCW-1:0] REF_LAST    = RCW'(REF_INIT_BEATS - 1);
   localparam logic [5:0]     SEARCH_LAST = 6'(SEARCH_ROWS);
   localparam logic [1:0]     CMP_LAST    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_CURR,
      S_LD_REF,
      S_CMP,
      S_SHIFT,
      S_FIN
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [CCW-1:0]   curr_cnt;
   logic [RCW-1:0]   ref_cnt;
   logic [1:0]       cmp_cnt;
   logic [5:0]       pos;

   logic             curr_hs;
   logic             ref_hs;
   logic             start_acc;
   logic             in_cmp;
   logic             ref_is_load;

   // Handshake decode. The ready registers are only ever high in the
   // states that consume the matching stream, so a handshake always
   // belongs to the current state.
   always_comb begin
      curr_hs     = curr_ready & curr_valid;
      ref_hs      = ref_ready & ref_valid;
      start_acc   = (state == S_IDLE) & start;
      in_cmp      = (state == S_CMP);
      ref_is_load = (state == S_LD_REF);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. The compare phase is a fixed four-cycle sweep of
   // abs_Control; the last position skips the reference shift and ends.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_LD_CURR;
            end
         end
         S_LD_CURR: begin
            if (curr_hs && (curr_cnt == CURR_LAST)) begin
               state_nxt = S_LD_REF;
            end
         end
         S_LD_REF: begin
            if (ref_hs && (ref_cnt == REF_LAST)) begin
               state_nxt = S_CMP;
            end
         end
         S_CMP: begin
            if (cmp_cnt == CMP_LAST) begin
               state_nxt = (pos == SEARCH_LAST) ? S_FIN : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ref_hs) begin
               state_nxt = S_CMP;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Beat, sweep and position counters; all cleared when a block starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         curr_cnt <= '0;
         ref_cnt  <= '0;
         cmp_cnt  <= '0;
         pos      <= '0;
      end else begin
         if (start_acc) begin
            curr_cnt <= '0;
            ref_cnt  <= '0;
            cmp_cnt  <= '0;
            pos      <= '0;
         end else begin
            if (curr_hs) begin
               curr_cnt <= curr_cnt + CCW'(1);
            end
            if (ref_hs && ref_is_load) begin
               ref_cnt <= ref_cnt + RCW'(1);
            end
            if (in_cmp) begin
               // Two-bit counter wraps back to 0 for the next position.
               cmp_cnt <= cmp_cnt + 2'd1;
            end
            if (ref_hs && (state == S_SHIFT)) begin
               pos <= pos + 6'd1;
            end
         end
      end
   end

   // CB pair latch; the array sees a constant selector for the whole run.
   always_ff @(posedge clk) begin
      if (rst) begin
         CB_select <= 1'b0;
      end else if (start_acc) begin
         CB_select <= cb_pair;
      end
   end

   // Sequence status and upstream ready, registered from the next state so
   // they line up with the state the feeder is actually in.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         curr_ready <= 1'b0;
         ref_ready  <= 1'b0;
      end else begin
         busy       <= (state_nxt != S_IDLE);
         done       <= (state_nxt == S_FIN);
         curr_ready <= (state_nxt == S_LD_CURR);
         ref_ready  <= (state_nxt == S_LD_REF) || (state_nxt == S_SHIFT);
      end
   end

   // Current-row path: one shift strobe per accepted beat, data held between.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_curr_enable   <= 1'b0;
         current_64pixels <= '0;
      end else begin
         in_curr_enable <= curr_hs;
         if (curr_hs) begin
            current_64pixels <= curr_data;
         end
      end
   end

   // Reference path: the beat is forwarded whole; during one-row shifts the
   // array only uses the low row, so the upper rows pass through untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         change_ref        <= 1'b0;
         ref_input_Control <= 1'b0;
         ref_8R_32         <= '0;
      end else begin
         change_ref <= ref_hs;
         if (ref_hs) begin
            ref_input_Control <= ref_is_load;
            ref_8R_32         <= ref_data;
         end
      end
   end

   // Compare tags: one abs_valid per sweep step, selector and position held
   // outside the compare window.
   always_ff @(posedge clk) begin
      if (rst) begin
         abs_valid   <= 1'b0;
         abs_Control <= 2'd0;
         pos_idx     <= 6'd0;
      end else begin
         abs_valid <= in_cmp;
         if (in_cmp) begin
            abs_Control <= cmp_cnt;
            pos_idx     <= pos;
         end
      end
   end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder (SEARCH_ROWS reduced to 2).
// A beat-counting reference model predicts every registered output each
// cycle; directed steps add reset, stall, noise and pattern scenarios.
module tb_pe_array_feeder;

   localparam int PIXEL = 8;
   localparam int X     = 32;
   localparam int CR    = 32;
   localparam int RI    = 4;
   localparam int SR    = 2;
   localparam int CW    = 2 * X * PIXEL;
   localparam int RW    = 8 * X * PIXEL;
   localparam int LIMIT = 3000;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            cb_pair;
   logic            busy;
   logic            done;
   logic [CW-1:0]   curr_data;
   logic            curr_valid;
   logic            curr_ready;
   logic [RW-1:0]   ref_data;
   logic            ref_valid;
   logic            ref_ready;
   logic [CW-1:0]   current_64pixels;
   logic            in_curr_enable;
   logic            CB_select;
   logic [1:0]      abs_Control;
   logic [RW-1:0]   ref_8R_32;
   logic            change_ref;
   logic            ref_input_Control;
   logic            abs_valid;
   logic [5:0]      pos_idx;

   always #5 clk = ~clk;

   pe_array_feeder #(
      .PIXEL(PIXEL), .X(X), .CURR_ROWS(CR), .REF_INIT_BEATS(RI), .SEARCH_ROWS(SR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cb_pair(cb_pair),
      .busy(busy), .done(done),
      .curr_data(curr_data), .curr_valid(curr_valid), .curr_ready(curr_ready),
      .ref_data(ref_data), .ref_valid(ref_valid), .ref_ready(ref_ready),
      .current_64pixels(current_64pixels), .in_curr_enable(in_curr_enable),
      .CB_select(CB_select), .abs_Control(abs_Control), .ref_8R_32(ref_8R_32),
      .change_ref(change_ref), .ref_input_Control(ref_input_Control),
      .abs_valid(abs_valid), .pos_idx(pos_idx)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: progress of the block counted in accepted beats and
   // issued compare cycles.
   bit            act;
   int            nc, nr, ns, ncmp;
   bit            m_cb;
   bit            e_curr_en, e_change, e_ric, e_absv;
   logic [1:0]    e_absc;
   logic [5:0]    e_pos;
   logic [CW-1:0] e_curr_data;
   logic [RW-1:0] e_ref_data;

   // Observed strobe tallies for the current run.
   int n_curr_en, n_load, n_shift, n_absv, n_done;

   logic [RW-1:0] pat_v;

   function automatic bit m_want_curr();
      return act && (nc < CR);
   endfunction
   function automatic bit m_want_ref();
      return act && (nc == CR) && (nr < RI);
   endfunction
   function automatic bit m_cmping();
      return act && (nr == RI) && (ncmp < 4 * (ns + 1));
   endfunction
   function automatic bit m_want_shift();
      return act && (nr == RI) && (ncmp == 4 * (ns + 1)) && (ns < SR);
   endfunction
   function automatic bit m_fin();
      return act && (ncmp == 4 * (SR + 1));
   endfunction

   task automatic model_clear();
      act = 1'b0; nc = 0; nr = 0; ns = 0; ncmp = 0; m_cb = 1'b0;
      e_curr_en = 1'b0; e_change = 1'b0; e_ric = 1'b0; e_absv = 1'b0;
      e_absc = '0; e_pos = '0; e_curr_data = '0; e_ref_data = '0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed(low64)=%h expected(low64)=%h", tag, obs[63:0], exp[63:0]);
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < CW / 32; i++) curr_data[i*32 +: 32] = $urandom();
      for (int i = 0; i < RW / 32; i++) ref_data[i*32 +: 32] = $urandom();
   endtask

   // One clock: advance the model by the edge, then compare all outputs.
   task automatic tick();
      bit wc, wr, cm, ws, fn;
      wc = m_want_curr(); wr = m_want_ref(); cm = m_cmping();
      ws = m_want_shift(); fn = m_fin();
      e_curr_en = 1'b0; e_change = 1'b0; e_absv = 1'b0;
      if (rst) begin
         model_clear();
      end else if (!act) begin
         if (start) begin
            act = 1'b1; nc = 0; nr = 0; ns = 0; ncmp = 0; m_cb = cb_pair;
         end
      end else if (wc) begin
         if (curr_valid) begin
            nc++; e_curr_en = 1'b1; e_curr_data = curr_data;
         end
      end else if (wr) begin
         if (ref_valid) begin
            nr++; e_change = 1'b1; e_ric = 1'b1; e_ref_data = ref_data;
         end
      end else if (cm) begin
         e_absv = 1'b1; e_absc = 2'(ncmp % 4); e_pos = 6'(ncmp / 4); ncmp++;
      end else if (ws) begin
         if (ref_valid) begin
            ns++; e_change = 1'b1; e_ric = 1'b0; e_ref_data = ref_data;
         end
      end else if (fn) begin
         act = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("busy", 64'(busy), 64'(act));
      chk("done", 64'(done), 64'(m_fin()));
      chk("curr_ready", 64'(curr_ready), 64'(m_want_curr()));
      chk("ref_ready", 64'(ref_ready), 64'(m_want_ref() || m_want_shift()));
      chk("CB_select", 64'(CB_select), 64'(m_cb));
      chk("in_curr_enable", 64'(in_curr_enable), 64'(e_curr_en));
      chkw("current_64pixels", RW'(current_64pixels), RW'(e_curr_data));
      chk("change_ref", 64'(change_ref), 64'(e_change));
      chk("ref_input_Control", 64'(ref_input_Control), 64'(e_ric));
      chkw("ref_8R_32", ref_8R_32, e_ref_data);
      chk("abs_valid", 64'(abs_valid), 64'(e_absv));
      chk("abs_Control", 64'(abs_Control), 64'(e_absc));
      chk("pos_idx", 64'(pos_idx), 64'(e_pos));
      n_curr_en += int'(in_curr_enable);
      if (change_ref) begin
         if (ref_input_Control) n_load++;
         else n_shift++;
      end
      n_absv += int'(abs_valid);
      n_done += int'(done);
   endtask

   task automatic clear_tallies();
      n_curr_en = 0; n_load = 0; n_shift = 0; n_absv = 0; n_done = 0;
   endtask

   // Run one full block search. pv = valid probability in percent.
   task automatic run_block(input int pv, input bit noise, input bit cb,
                            input int hold, input bit pat,
                            output int rel_done, output int first_busy, output int last_busy);
      int  base;
      int  guard;
      int  hold_left;
      bit  holding;
      bit  pat_now;
      clear_tallies();
      rel_done = -1; first_busy = -1; last_busy = -1;
      hold_left = hold;
      base = cyc;
      start = 1'b1; cb_pair = cb;
      curr_valid = 1'b0; ref_valid = 1'b0;
      rand_data();
      tick();
      start = 1'b0;
      if (busy) begin first_busy = cyc - base; last_busy = cyc - base; end
      guard = 0;
      while (act && guard < LIMIT) begin
         guard++;
         rand_data();
         curr_valid = ($urandom_range(99) < pv);
         ref_valid  = ($urandom_range(99) < pv);
         if (noise) begin
            cb_pair = ~cb_pair;
            start = 1'($urandom_range(1));
         end
         holding = 1'b0;
         pat_now = 1'b0;
         if (hold_left > 0 && m_want_shift()) begin
            ref_valid = 1'b0; hold_left--; holding = 1'b1;
         end else if (pat && m_want_shift()) begin
            ref_data = pat_v; ref_valid = 1'b1; pat_now = 1'b1;
         end
         tick();
         if (holding) begin
            chk("hold_no_change_ref", 64'(change_ref), 64'd0);
            chk("hold_no_abs_valid", 64'(abs_valid), 64'd0);
            chk("hold_pos_idx", 64'(pos_idx), 64'(ns));
         end
         if (pat_now) begin
            chkw("shift_pattern_ref", ref_8R_32, pat_v);
            chk("shift_pattern_ric", 64'(ref_input_Control), 64'd0);
         end
         if (busy) begin
            if (first_busy < 0) first_busy = cyc - base;
            last_busy = cyc - base;
         end
         if (done) rel_done = cyc - base;
      end
      start = 1'b0;
      chk("run_bound", 64'(guard >= LIMIT), 64'd0);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_curr_en_cnt"}, 64'(n_curr_en), 64'(CR));
      chk({tag, "_load_cnt"}, 64'(n_load), 64'(RI));
      chk({tag, "_absv_cnt"}, 64'(n_absv), 64'(4 * (SR + 1)));
      chk({tag, "_shift_cnt"}, 64'(n_shift), 64'(SR));
      chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
   endtask

   initial begin
      int rd, fb, lb;
      int guard;
      model_clear();
      clear_tallies();
      rst = 1'b1; start = 1'b0; cb_pair = 1'b0;
      curr_valid = 1'b0; ref_valid = 1'b0;
      curr_data = '0; ref_data = '0;
      pat_v = '1;
      for (int i = 0; i < X; i++) pat_v[i*8 +: 8] = 8'h5A;

      // Reset state.
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Valids always high: fixed timeline.
      run_block(100, 1'b0, 1'b0, 0, 1'b0, rd, fb, lb);
      chk("A_done_cycle", 64'(rd), 64'd51);
      chk("A_first_busy", 64'(fb), 64'd1);
      chk("A_last_busy", 64'(lb), 64'd51);
      chk_counts("A");
      repeat (3) tick();

      // Random upstream gaps.
      for (int r = 0; r < 2; r++) begin
         run_block(50, 1'b0, 1'($urandom_range(1)), 0, 1'b0, rd, fb, lb);
         chk_counts("B");
         chk("B_busy_through_done", 64'(lb), 64'(rd));
         repeat (2) tick();
      end

      // cb_pair toggling and start pulses while busy.
      run_block(100, 1'b1, 1'b1, 0, 1'b0, rd, fb, lb);
      chk_counts("C");
      chk("C_cb_held", 64'(CB_select), 64'd1);
      repeat (3) tick();

      // Reset after two initial reference beats.
      clear_tallies();
      start = 1'b1; cb_pair = 1'b1; curr_valid = 1'b1; ref_valid = 1'b1;
      rand_data();
      tick();
      start = 1'b0;
      guard = 0;
      while (nr < 2 && guard < 200) begin
         guard++;
         rand_data();
         tick();
      end
      chk("D_reach_ld_ref", 64'(guard >= 200), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("D_rst_busy", 64'(busy), 64'd0);
      chk("D_rst_ref_ready", 64'(ref_ready), 64'd0);
      chkw("D_rst_ref_data", ref_8R_32, '0);
      chk("D_rst_cb", 64'(CB_select), 64'd0);
      curr_valid = 1'b0; ref_valid = 1'b0;
      repeat (5) tick();
      chk("D_no_done", 64'(n_done), 64'd0);
      run_block(70, 1'b0, 1'b0, 0, 1'b0, rd, fb, lb);
      chk_counts("D2");
      repeat (2) tick();

      // Stalled shift stream.
      run_block(100, 1'b0, 1'b0, 20, 1'b0, rd, fb, lb);
      chk_counts("E");
      chk("E_done_cycle", 64'(rd), 64'd71);
      repeat (2) tick();

      // Shift beats with a fixed row pattern.
      run_block(100, 1'b0, 1'b0, 0, 1'b1, rd, fb, lb);
      chk_counts("F");
      chkw("F_last_ref", ref_8R_32, pat_v);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
